operand_shifter_seq: RTL and testbench

- Multi-cycle, parametrised shifter operand unit for the ARM core.
- Covers shift-by-immediate, shift-by-register, RRX and rotated-immediate operands (immediate rotate: src = zero-extended imm8, ROR, register semantics, amt = 2*rot).
- Produces the shifted value plus shifter carry-out.
- Sits between register read and ALU/address-generation; valid/ready on both sides so the issue stage can stall on long shifts.

---
 rtl/operand_shifter_seq.sv | 175 +++++++++++++++++
 tb/tb_operand_shifter_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_shifter_seq.sv
// Multi-cycle ARM shifter operand unit: LSL/LSR/ASR/ROR/RRX, up to MAX_STEP bits per cycle.
// Optional OPSH_PERF_CNT_EN adds busy_cycles/op_count performance counters.
module operand_shifter_seq #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_STEP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src,
  input  logic [1:0]        shift_type,
  input  logic [7:0]        amt,
  input  logic              amt_is_reg,
  input  logic              c_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
`ifdef OPSH_PERF_CNT_EN
  output logic [31:0]       busy_cycles,
  output logic [31:0]       op_count,
`endif
  output logic              c_out
);

  localparam int unsigned CW = $clog2(DATA_W) + 1;
  localparam int unsigned LW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  logic [1:0]     typ;
  logic [CW-1:0]  rem;

  logic [CW-1:0]     acc_n;
  logic              acc_direct;
  logic [DATA_W-1:0] acc_res;
  logic              acc_c;
  int unsigned       amt_u;
  int unsigned       n_u;

  logic [CW-1:0]     step;
  logic [LW-1:0]     idx_lsl;
  logic [LW-1:0]     idx_lsr;
  logic [DATA_W-1:0] nxt;
  logic              nxt_c;

  assign in_ready = rst_n && (state == IDLE) && !flush;

  // Accept-time decode: either a direct result (no SHIFT cycles) or a shift count n
  always_comb begin
    amt_u      = 32'(amt);
    n_u        = amt_u;
    acc_direct = 1'b0;
    acc_res    = src;
    acc_c      = c_in;
    if (amt_u == 0) begin
      if (!amt_is_reg && (shift_type == 2'b01 || shift_type == 2'b10)) begin
        n_u = DATA_W;
      end else begin
        acc_direct = 1'b1;
        if (!amt_is_reg && shift_type == 2'b11) begin
          acc_res = {c_in, src[DATA_W-1:1]};
          acc_c   = src[0];
        end
      end
    end else if (shift_type == 2'b11) begin
      n_u = amt_u % DATA_W;
      if (n_u == 0) begin
        acc_direct = 1'b1;
        acc_c      = src[DATA_W-1];
      end
    end else if (amt_u > DATA_W) begin
      if (amt_is_reg && shift_type != 2'b10) begin
        acc_direct = 1'b1;
        acc_res    = '0;
        acc_c      = 1'b0;
      end else begin
        n_u = DATA_W;
      end
    end
    acc_n = CW'(n_u);
  end

  always_comb begin
    step    = (rem > CW'(MAX_STEP)) ? CW'(MAX_STEP) : rem;
    idx_lsl = LW'(CW'(DATA_W) - step);
    idx_lsr = LW'(step - CW'(1));
    nxt     = result;
    nxt_c   = c_out;
    if (step != '0) begin
      case (typ)
        2'b00: begin
          nxt   = result << step;
          nxt_c = result[idx_lsl];
        end
        2'b01: begin
          nxt   = result >> step;
          nxt_c = result[idx_lsr];
        end
        2'b10: begin
          nxt   = $signed(result) >>> step;
          nxt_c = result[idx_lsr];
        end
        default: begin
          nxt   = (result >> step) | (result << (CW'(DATA_W) - step));
          nxt_c = nxt[DATA_W-1];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      typ       <= '0;
      rem       <= '0;
      result    <= '0;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            typ <= shift_type;
            if (acc_direct || acc_n == '0) begin
              result    <= acc_res;
              c_out     <= acc_c;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              result <= src;
              c_out  <= c_in;
              rem    <= acc_n;
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          result <= nxt;
          c_out  <= nxt_c;
          rem    <= rem - step;
          if (rem == step) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OPSH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cycles <= '0;
      op_count    <= '0;
    end else begin
      if (state == SHIFT) busy_cycles <= busy_cycles + 32'd1;
      if (state == DONE && out_ready && !flush) op_count <= op_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_shifter_seq.sv
// Scoreboard bench for operand_shifter_seq; checks perf counters when OPSH_PERF_CNT_EN is defined.
module tb_operand_shifter_seq;
  localparam int W = 32;
  localparam int S = 8;

  logic         clk, rst_n, flush, in_valid, in_ready, amt_is_reg, c_in;
  logic         out_valid, out_ready, c_out;
  logic [W-1:0] src, result;
  logic [1:0]   shift_type;
  logic [7:0]   amt;
`ifdef OPSH_PERF_CNT_EN
  logic [31:0]  busy_cycles, op_count;
`endif

  operand_shifter_seq #(.DATA_W(W), .MAX_STEP(S)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src(src), .shift_type(shift_type), .amt(amt), .amt_is_reg(amt_is_reg), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
`ifdef OPSH_PERF_CNT_EN
    .busy_cycles(busy_cycles), .op_count(op_count),
`endif
    .c_out(c_out)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    int           due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   npush = 0;
  int   rdy_mode = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: ARM shifter operand rules in plain arithmetic; due holds SHIFT cycle count
  function automatic exp_t model(input logic [W-1:0] s, input logic [1:0] t, input int a,
                                 input bit is_reg, input logic ci);
    exp_t e;
    int n;
    logic [2*W-1:0] u;
    logic signed [2*W-1:0] sg;
    n = a;
    e.res = s; e.c = ci; e.due = 0;
    if (a == 0) begin
      if (is_reg || t == 2'd0) return e;
      if (t == 2'd3) begin
        e.res = {ci, s[W-1:1]}; e.c = s[0];
        return e;
      end
      n = W;
    end else if (t == 2'd3) begin
      n = a % W;
      if (n == 0) begin e.c = s[W-1]; return e; end
    end else if (a > W) begin
      if (is_reg && t != 2'd2) begin e.res = '0; e.c = 1'b0; return e; end
      n = W;
    end
    case (t)
      2'd0: begin u = {{W{1'b0}}, s} << n; e.res = u[W-1:0]; e.c = u[W]; end
      2'd1: begin u = {s, {W{1'b0}}} >> n; e.res = u[2*W-1:W]; e.c = u[W-1]; end
      2'd2: begin sg = {s, {W{1'b0}}}; sg = sg >>> n; e.res = sg[2*W-1:W]; e.c = sg[W-1]; end
      default: begin u = {s, s} >> n; e.res = u[W-1:0]; e.c = e.res[W-1]; end
    endcase
    e.due = (n + S - 1) / S;
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] s, input logic [1:0] t, input int a,
                       input bit is_reg, input logic ci, input bit push);
    exp_t e;
    bit got = 0;
    @(negedge clk);
    src = s; shift_type = t; amt = 8'(a); amt_is_reg = is_reg; c_in = ci; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (in_ready) begin
        @(posedge clk); #1;
        got = 1;
        if (push) begin
          e = model(s, t, a, is_reg, ci);
          e.due = cyc + e.due;
          q.push_back(e);
          npush++;
        end
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    src = $urandom; shift_type = 2'($urandom); amt = 8'($urandom); c_in = 1'($urandom);
    if (!got) check("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) check("valid_timeout", 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    case (rdy_mode)
      0: out_ready = ($urandom_range(0, 3) != 0);
      1: out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pop on first cycle of each presented result, then watch it stays put
  bit   holding = 0;
  bit   hs, fl;
  exp_t held;
  always @(posedge clk) begin
    hs = out_valid && out_ready && !flush && rst_n;
    fl = flush;
    #2;
    if (!rst_n || fl) holding = 0;
    else begin
      if (hs) begin
        holding = 0;
        check("idle_after_hs", out_valid, 1'b0);
      end else if (out_valid && !holding) begin
        if (q.size() == 0) check("unexpected_out_valid", out_valid, 1'b0);
        else begin
          held = q.pop_front();
          holding = 1;
          check("result", result, held.res);
          check("c_out", c_out, held.c);
          check("latency_cycle", cyc, held.due);
        end
      end else if (out_valid && holding) begin
        check("hold_result", result, held.res);
        check("hold_c_out", c_out, held.c);
        check("in_ready_in_done", in_ready, 1'b0);
      end
    end
  end

  initial begin
    logic [W-1:0] s;
    logic [1:0]   t;
    int           a;
    bit           r;
`ifdef OPSH_PERF_CNT_EN
    logic [31:0]  busy0;
`endif
    rst_n = 0; flush = 0; in_valid = 0; src = '0; shift_type = '0; amt = '0;
    amt_is_reg = 0; c_in = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_c_out", c_out, 1'b0);
    rst_n = 1; #1;
    check("in_ready_after_rst", in_ready, 1'b1);

    issue(32'h8000_0001, 2'd0, 4,   1, 0, 1);
    issue(32'h8000_0000, 2'd1, 0,   0, 0, 1);
    issue(32'h8000_0000, 2'd2, 200, 1, 0, 1);
    issue(32'h8000_0000, 2'd0, 33,  1, 1, 1);
    issue(32'h0000_0003, 2'd3, 0,   0, 1, 1);
    issue(32'h0000_00F0, 2'd3, 36,  1, 0, 1);
    issue(32'h8000_0000, 2'd3, 32,  1, 0, 1);
    issue(32'h0000_0001, 2'd0, 32,  1, 0, 1);
    issue(32'h8000_0000, 2'd1, 32,  1, 0, 1);
    issue(32'h1234_5678, 2'd2, 0,   1, 1, 1);
    wait_drain();

    rdy_mode = 2;
    issue(32'h8000_0001, 2'd0, 4, 1, 0, 1);
    wait_valid();
    repeat (5) @(negedge clk);
    rdy_mode = 1;
    issue(32'hDEAD_BEEF, 2'd1, 7, 0, 0, 1);
    wait_drain();

    rdy_mode = 0;
    for (int i = 0; i < 150; i++) begin
      s = $urandom; t = 2'($urandom); r = 1'($urandom);
      if (r) begin
        case ($urandom_range(0, 4))
          0: a = 0;
          1: a = W - 1;
          2: a = W;
          3: a = W + 1;
          default: a = $urandom_range(0, 255);
        endcase
      end else begin
        a = $urandom_range(0, 31);
        if (t == 2'd3 && $urandom_range(0, 1) == 1) begin
          s = W'($urandom_range(0, 255));
          a = 2 * $urandom_range(0, 15);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(s, t, a, r, 1'($urandom), 1);
    end
    wait_drain();

    rdy_mode = 1;
`ifdef OPSH_PERF_CNT_EN
    busy0 = busy_cycles;
`endif
    issue(32'h8000_0000, 2'd1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    flush = 1; #1;
    check("in_ready_flush", in_ready, 1'b0);
    @(negedge clk);
    flush = 0; #1;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
`ifdef OPSH_PERF_CNT_EN
    check("busy_after_flush", busy_cycles - busy0, 32'd3);
`endif
    repeat (8) @(negedge clk);

    rdy_mode = 2;
    issue(32'h0000_00F0, 2'd0, 4, 1, 0, 1);
    wait_valid();
    rdy_mode = 1; out_ready = 1; flush = 1;
    @(negedge clk);
    flush = 0; #1;
    check("flush_done_out_valid", out_valid, 1'b0);
    repeat (3) @(negedge clk);
`ifdef OPSH_PERF_CNT_EN
    check("op_count", op_count, 32'(npush - 1));
`endif

    issue(32'h8000_0000, 2'd1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 0; #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_result", result, '0);
    check("midrst_c_out", c_out, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
`ifdef OPSH_PERF_CNT_EN
    check("midrst_busy", busy_cycles, '0);
    check("midrst_op_count", op_count, '0);
`endif
    @(negedge clk);
    rst_n = 1;
    repeat (6) @(negedge clk);
    check("post_rst_quiet", out_valid, 1'b0);
    issue(32'h0000_0081, 2'd2, 1, 1, 0, 1);
    wait_drain();
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
